// File: rtl/lfsr_word_arbiter.sv
// lfsr_word_arbiter
//
// Shares one Fibonacci LFSR among NREQ requesters. Requests are served
// round-robin; for each grant the LFSR is stepped WW times (one bit per
// clock) to assemble a WW-bit word, which is returned with a one-cycle
// valid strobe. Seed loads are accepted only between words.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting; accepts seed loads, else samples i_req and grants
// GEN   | stepping the LFSR, one output bit shifted into the word per clock
// DONE  | word latched in o_word, o_valid high for this single cycle
//
// Ports:
//   i_clk    clock, rising edge
//   i_reset  synchronous active-high reset
//   i_req    level requests, one bit per requester
//   i_load   seed load strobe (honoured in IDLE only)
//   i_seed   seed value; zero loads INITIAL_FILL instead
//   o_busy   high in GEN and DONE
//   o_grant  one-hot owner of the word in flight, zero in IDLE
//   o_valid  one-cycle strobe, o_word valid for the o_grant owner
//   o_word   last completed word, held until the next one completes

module lfsr_word_arbiter #(
    parameter int              LN           = 8,
    parameter logic [LN-1:0]   TAPS         = LN'('h2d),
    parameter logic [LN-1:0]   INITIAL_FILL = LN'(1),
    parameter int              NREQ         = 4,
    parameter int              WW           = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [NREQ-1:0]   i_req,
    input  logic              i_load,
    input  logic [LN-1:0]     i_seed,
    output logic              o_busy,
    output logic [NREQ-1:0]   o_grant,
    output logic              o_valid,
    output logic [WW-1:0]     o_word
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(WW + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GEN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [LN-1:0]     r_sreg;
    logic [WW-1:0]     r_wsr;
    logic [CW-1:0]     r_cnt;
    logic [PW-1:0]     r_ptr;
    logic [NREQ-1:0]   r_grant;
    logic [WW-1:0]     r_word;

    logic              w_fb;
    logic [LN-1:0]     w_sreg_step;
    logic [WW-1:0]     w_wsr_step;

    logic              w_do_load;
    logic              w_do_grant;
    logic              w_do_step;
    logic              w_last_step;

    logic              w_hi_found;
    logic [PW-1:0]     w_hi_idx;
    logic [PW-1:0]     w_lo_idx;
    logic [PW-1:0]     w_winner;
    logic [PW-1:0]     w_ptr_next;
    logic [NREQ-1:0]   w_winner_oh;

    // LFSR step: output bit is sreg[0], feedback enters at the MSB.
    assign w_fb        = ^(r_sreg & TAPS);
    assign w_sreg_step = {w_fb, r_sreg[LN-1:1]};

    // Output bit enters the word at the MSB so the first bit ends in bit 0.
    generate
        if (WW == 1) begin : g_wsr_1
            assign w_wsr_step = r_sreg[0];
        end else begin : g_wsr_n
            assign w_wsr_step = {r_sreg[0], r_wsr[WW-1:1]};
        end
    endgenerate

    // Round-robin pick: lowest set bit at or above the pointer, otherwise
    // the lowest set bit overall (the wrap-around case).
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_lo_idx = PW'(i);
                if (PW'(i) >= r_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = PW'(i);
                end
            end
        end
        w_winner = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    assign w_ptr_next  = (w_winner == PW'(NREQ - 1)) ? '0 : w_winner + PW'(1);
    assign w_winner_oh = NREQ'(1) << w_winner;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_do_load    = 1'b0;
        w_do_grant   = 1'b0;
        w_do_step    = 1'b0;
        w_last_step  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_load) begin
                    w_do_load = 1'b1;
                end else if (|i_req) begin
                    w_do_grant   = 1'b1;
                    w_state_next = S_GEN;
                end
            end
            S_GEN: begin
                w_do_step = 1'b1;
                if (r_cnt == CW'(WW - 1)) begin
                    w_last_step  = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sreg  <= INITIAL_FILL;
            r_wsr   <= '0;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_grant <= '0;
            r_word  <= '0;
        end else begin
            if (w_do_load) begin
                // A zero seed would lock the LFSR up; substitute the fill.
                r_sreg <= (i_seed == '0) ? INITIAL_FILL : i_seed;
            end
            if (w_do_grant) begin
                r_grant <= w_winner_oh;
                r_ptr   <= w_ptr_next;
                r_cnt   <= '0;
            end
            if (w_do_step) begin
                r_sreg <= w_sreg_step;
                r_wsr  <= w_wsr_step;
                r_cnt  <= r_cnt + CW'(1);
            end
            if (w_last_step) begin
                r_word <= w_wsr_step;
            end
            if (r_state == S_DONE) begin
                r_grant <= '0;
            end
        end
    end

    assign o_busy  = (r_state != S_IDLE);
    assign o_valid = (r_state == S_DONE);
    assign o_grant = r_grant;
    assign o_word  = r_word;

endmodule

// File: doc/lfsr_word_arbiter.md
# lfsr_word_arbiter

Shares a single Fibonacci LFSR generator among NREQ requesters. Each served request receives one WW-bit pseudo-random word. The block arbitrates round-robin, steps the LFSR one bit per clock to assemble each word, and returns it with a one-cycle valid strobe. It also accepts seed loads between words. It sits between the scrambler/dither consumers and the shared LFSR state, so that several channels draw from one non-overlapping sequence.

## Interface
- LN, 8, LFSR register length / polynomial degree.
- TAPS, 8'h2d, feedback tap mask (LN bits).
- INITIAL_FILL, {LN-1 zeros, 1}, LFSR state after reset or after a zero-seed load.
- NREQ, 4, number of requesters (2..16).
- WW, 8, output word width in bits (1..32).

Ports:
- i_clk  in  1  clock; every register updates on the rising edge.
- i_reset  in  1  reset, synchronous, active-high.
- i_req  in  NREQ  level request, one bit per requester.
- i_load  in  1  seed load strobe; honoured only while o_busy is low.
- i_seed  in  LN  seed value presented with i_load.
- o_busy  out  1  high in GEN and DONE states.
- o_grant  out  NREQ  one-hot: the requester being served; zero in IDLE.
- o_valid  out  1  one-cycle strobe: o_word is valid for the o_grant owner.
- o_word  out  WW  assembled word; holds its value until the next word completes.

## Operation
- LFSR step, identical to the team's Fibonacci generator:
  - Output bit is sreg[0].
  - sreg shifts right by one.
  - New sreg[LN-1] = ^(sreg & TAPS).
  - The LFSR advances only in GEN.
- Word assembly: each step shifts sreg[0] into the MSB of the word shift register, i.e. {sreg[0], w[WW-1:1]}. After WW steps, the first generated bit sits in o_word[0].
- FSM states: IDLE, GEN, DONE.
  - IDLE, i_load high: load sreg with i_seed. If i_seed == 0, load INITIAL_FILL instead (lock-up guard). Stay in IDLE; i_req is ignored this cycle.
  - IDLE, i_load low, any i_req: pick the winner, set o_grant, clear the step counter, go to GEN.
  - GEN: one step per cycle. After the WW-th step, latch the word into o_word and go to DONE.
  - DONE: o_valid = 1 for this cycle only. Next cycle: IDLE, o_grant cleared.
- Arbitration:
  - The round-robin pointer starts at 0.
  - Winner = first set bit of i_req at index ≥ pointer, wrapping around modulo NREQ.
  - On grant, pointer ← winner+1 (mod NREQ).
  - i_req is sampled only in IDLE. Dropping or raising i_req during GEN/DONE has no effect on the word in flight.
  - A requester that keeps i_req high after its o_valid is served again only after every other active requester.
- i_load while o_busy is high is ignored; it is not queued.
- The counter width is clog2(WW+1). No arithmetic beyond this counter and the pointer increment.

## Timing
- Reset values: o_busy=0, o_grant=0, o_valid=0, o_word=0, sreg=INITIAL_FILL, pointer=0, state=IDLE.
- Request sampled in IDLE at edge t:
  - GEN occupies cycles t+1 .. t+WW.
  - o_valid is high in cycle t+WW+1.
  - IDLE resumes at t+WW+2.
  - Throughput is one word per WW+2 cycles.
- Seed load: sreg takes the new value at the edge where i_load is sampled in IDLE. The next grant is 1 cycle later than it would have been.
- Reset mid-GEN or mid-DONE: the partial word is discarded and no o_valid is issued. All registers return to their reset values, including the pointer.
- With WW == LN, each o_word equals the sreg value at the start of that word. The verifier may use this property.

## Test plan
- Defaults, reset, then i_req=4'b0001 held: o_valid strobes every 10 cycles. o_word sequence is 8'h01, 8'h29, 8'hFF; o_grant=4'b0001 each time.
- i_req=4'b1111 held: grants 0001, 0010, 0100, 1000, 0001. Words continue the single sequence 01, 29, FF, … with no repeats or gaps.
- IDLE, i_load=1, i_seed=8'h29, with i_req=4'b0010 in the same cycle: first word is 8'h29, delivered one cycle later than without the load; o_grant=0010.
- i_load with i_seed=0: the next word is 8'h01 (INITIAL_FILL).
- i_load pulsed during GEN with i_seed=8'hAA: ignored; words continue the 01/29/FF sequence.
- i_reset asserted at the 4th GEN cycle: no o_valid is issued. Outputs are zero next cycle. The next word is 8'h01 to requester 0 when all of i_req is set.
